// File: rtl/mux_8x1_pkg.sv
// ---------------------------------------------------------------------------
// mux_pkg
// Shared constants and helpers for the N:1 lane selector.
//   DEFAULT_NUM_INP : default number of input lanes (8).
//   lanes_from_sel  : number of lanes addressable by a select of given width,
//                     handy for checkers that only know the select width.
// ---------------------------------------------------------------------------
package mux_pkg;

  localparam int DEFAULT_NUM_INP = 8;

  function automatic int lanes_from_sel(input int sel_w);
    return 1 << sel_w;
  endfunction

endpackage : mux_pkg

// File: rtl/mux_8x1_if.sv
// ---------------------------------------------------------------------------
// mux_8x1_if
// Bundle of the selector's data signals.
//   inp         : packed lanes, lane k = inp[k*WIDTH +: WIDTH], lane 0 at LSBs
//   sel         : lane index
//   in_valid    : qualifies inp/sel for the registered stage
//   out         : combinational selected lane
//   sel_err     : combinational, high when sel >= NUM_INP
//   out_q       : registered selected lane
//   out_q_valid : registered in_valid
//   out_q_err   : registered (in_valid & sel_err)
// Handshake: in_valid is a plain qualifier with no ready/backpressure; the
// selector accepts a new lane every cycle and out_q_valid marks, one cycle
// later, the cycles whose out_q/out_q_err came from a qualified input.
// ---------------------------------------------------------------------------
interface mux_8x1_if
  import mux_pkg::*;
#(
  parameter int NUM_INP = DEFAULT_NUM_INP,
  parameter int WIDTH   = 1
);
  localparam int NUM_SEL = $clog2(NUM_INP);

  logic [NUM_INP*WIDTH-1:0] inp;
  logic [NUM_SEL-1:0]       sel;
  logic                     in_valid;
  logic [WIDTH-1:0]         out;
  logic                     sel_err;
  logic [WIDTH-1:0]         out_q;
  logic                     out_q_valid;
  logic                     out_q_err;

  modport master (
    output inp, sel, in_valid,
    input  out, sel_err, out_q, out_q_valid, out_q_err
  );

  modport slave (
    input  inp, sel, in_valid,
    output out, sel_err, out_q, out_q_valid, out_q_err
  );

endinterface : mux_8x1_if

// File: rtl/mux_8x1_out_reg.sv
// ---------------------------------------------------------------------------
// mux_out_reg
// WIDTH+2 bit capture register behind the selector.
//   clk, rst : clock and asynchronous active-high reset
//   data_i   : selected lane, captured only when valid_i is high
//   valid_i  : input qualifier
//   err_i    : out-of-range select flag
//   data_o   : held lane (keeps its value while valid_i is low)
//   valid_o  : registered valid_i
//   err_o    : registered (valid_i & err_i)
// ---------------------------------------------------------------------------
module mux_out_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  input  logic             err_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             err_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  always_comb begin
    data_d  = valid_i ? data_i : data_q;
    valid_d = valid_i;
    // An error is only meaningful for a qualified input.
    err_d   = valid_i & err_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign err_o   = err_q;

endmodule : mux_out_reg

// File: rtl/mux_8x1.sv
// ---------------------------------------------------------------------------
// mux_8x1
// Parameterised N:1 lane selector with a zero-latency combinational output
// and a one-cycle registered copy carrying a valid and an error flag.
//   clk, rst : clock for the registered stage; asynchronous active-high reset
//              that clears only the registered stage
//   bus      : mux_8x1_if slave (inp, sel, in_valid in; out, sel_err,
//              out_q, out_q_valid, out_q_err out)
// A select at or beyond NUM_INP (possible only for non power-of-two lane
// counts) yields out = 0 and sel_err = 1.
// ---------------------------------------------------------------------------
module mux_8x1
  import mux_pkg::*;
#(
  parameter int NUM_INP = DEFAULT_NUM_INP,
  parameter int WIDTH   = 1
) (
  input logic       clk,
  input logic       rst,
  mux_8x1_if.slave  bus
);

  localparam int NUM_SEL = $clog2(NUM_INP);

  logic [WIDTH-1:0] out_c;
  logic             sel_err_c;

  // Scan all legal lanes; if none matches, the select is out of range and
  // the defaults (zero data, error set) stand.
  always_comb begin
    out_c     = '0;
    sel_err_c = 1'b1;
    for (int k = 0; k < NUM_INP; k++) begin
      if (bus.sel == NUM_SEL'(k)) begin
        out_c     = bus.inp[k*WIDTH +: WIDTH];
        sel_err_c = 1'b0;
      end
    end
  end

  assign bus.out     = out_c;
  assign bus.sel_err = sel_err_c;

  mux_out_reg #(
    .WIDTH (WIDTH)
  ) u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .data_i  (out_c),
    .valid_i (bus.in_valid),
    .err_i   (sel_err_c),
    .data_o  (bus.out_q),
    .valid_o (bus.out_q_valid),
    .err_o   (bus.out_q_err)
  );

endmodule : mux_8x1

// File: tb/tb_mux_8x1.sv
// ---------------------------------------------------------------------------
// tb_mux_8x1
// Three selector instances: 8x1-bit, 5x1-bit (non power of two) and 8x4-bit.
// Stimulus is driven on the falling edge; combinational outputs are checked
// 1ns later, the expected registered response is pushed into a per-instance
// queue and a monitor pops and compares 1ns after every rising edge.
// ---------------------------------------------------------------------------
module tb_mux_8x1;
  import mux_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  mux_8x1_if #(.NUM_INP(8), .WIDTH(1)) bus_a ();
  mux_8x1_if #(.NUM_INP(5), .WIDTH(1)) bus_b ();
  mux_8x1_if #(.NUM_INP(8), .WIDTH(4)) bus_c ();

  mux_8x1 #(.NUM_INP(8), .WIDTH(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  mux_8x1 #(.NUM_INP(5), .WIDTH(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  mux_8x1 #(.NUM_INP(8), .WIDTH(4)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  // ---------------- scoreboard state ----------------
  int vectors     = 0;
  int miscompares = 0;

  // {out_q_err, out_q_valid, out_q (zero-extended to 4 bits)}
  logic [5:0] exp_q0[$];
  logic [5:0] exp_q1[$];
  logic [5:0] exp_q2[$];

  logic [31:0] c_inp[3];
  logic [2:0]  c_sel[3];
  logic        c_v[3];
  logic [3:0]  held[3];

  // ---------------- reference model ----------------
  function automatic int n_of(input int d);
    return (d == 1) ? 5 : 8;
  endfunction

  function automatic int w_of(input int d);
    return (d == 2) ? 4 : 1;
  endfunction

  function automatic logic sel_bad(input int d, input logic [2:0] sel);
    return int'(sel) >= n_of(d);
  endfunction

  function automatic logic [3:0] lane(input int d, input logic [31:0] inp,
                                      input logic [2:0] sel);
    logic [31:0] sh;
    if (sel_bad(d, sel)) return 4'h0;
    sh = inp >> (int'(sel) * w_of(d));
    return sh[3:0] & 4'((1 << w_of(d)) - 1);
  endfunction

  // ---------------- DUT observation ----------------
  function automatic logic [5:0] comb_of(input int d);
    case (d)
      0:       return {1'b0, bus_a.sel_err, 3'b000, bus_a.out};
      1:       return {1'b0, bus_b.sel_err, 3'b000, bus_b.out};
      default: return {1'b0, bus_c.sel_err, bus_c.out};
    endcase
  endfunction

  function automatic logic [5:0] reg_of(input int d);
    case (d)
      0:       return {bus_a.out_q_err, bus_a.out_q_valid, 3'b000, bus_a.out_q};
      1:       return {bus_b.out_q_err, bus_b.out_q_valid, 3'b000, bus_b.out_q};
      default: return {bus_c.out_q_err, bus_c.out_q_valid, bus_c.out_q};
    endcase
  endfunction

  task automatic chk(input string nm, input int d, input logic [5:0] act,
                     input logic [5:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d: got %h expected %h (t=%0t)", nm, d, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply();
    bus_a.inp = c_inp[0][7:0];  bus_a.sel = c_sel[0]; bus_a.in_valid = c_v[0];
    bus_b.inp = c_inp[1][4:0];  bus_b.sel = c_sel[1]; bus_b.in_valid = c_v[1];
    bus_c.inp = c_inp[2];       bus_c.sel = c_sel[2]; bus_c.in_valid = c_v[2];
  endtask

  task automatic check_comb(input string nm, input int d);
    chk(nm, d, comb_of(d), {1'b0, sel_bad(d, c_sel[d]), lane(d, c_inp[d], c_sel[d])});
  endtask

  // Expected registered value after the next rising edge.
  task automatic push_exp(input int d);
    logic [5:0] e;
    if (c_v[d]) held[d] = lane(d, c_inp[d], c_sel[d]);
    e = {c_v[d] & sel_bad(d, c_sel[d]), c_v[d], held[d]};
    case (d)
      0:       exp_q0.push_back(e);
      1:       exp_q1.push_back(e);
      default: exp_q2.push_back(e);
    endcase
  endtask

  task automatic step();
    @(negedge clk);
    apply();
    #1;
    for (int d = 0; d < 3; d++) begin
      check_comb("comb", d);
      push_exp(d);
    end
  endtask

  task automatic idle_others();
    for (int d = 1; d < 3; d++) begin
      c_inp[d] = $urandom;
      c_sel[d] = 3'($urandom_range(0, 7));
      c_v[d]   = 1'b0;
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q0.size() > 0) chk("reg", 0, reg_of(0), exp_q0.pop_front());
      if (exp_q1.size() > 0) chk("reg", 1, reg_of(1), exp_q1.pop_front());
      if (exp_q2.size() > 0) chk("reg", 2, reg_of(2), exp_q2.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      c_inp[d] = '0; c_sel[d] = '0; c_v[d] = 1'b0; held[d] = '0;
    end
    apply();
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) chk("reset_state", d, reg_of(d), 6'h00);

    @(negedge clk);
    rst = 1'b0;

    // Combinational sweep of every select value, 5ns apart.
    c_inp[0] = 32'b10110011;
    for (int s = 0; s < 8; s++) begin
      c_sel[0] = 3'(s);
      apply();
      #1;
      check_comb("sweep", 0);
      #4;
    end
    #1;
    for (int d = 0; d < 3; d++) chk("idle_hold", d, reg_of(d), 6'h00);

    // Capture sel=3 then sel=7, then drop in_valid.
    idle_others();
    c_sel[0] = 3'd3; c_v[0] = 1'b1; step();
    c_sel[0] = 3'd7;                step();
    c_v[0]   = 1'b0;                step();
    c_sel[0] = 3'd2;                step();

    // Asynchronous reset between edges, held across an edge with valid input.
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) chk("async_rst", d, reg_of(d), 6'h00);
    for (int d = 0; d < 3; d++) c_v[d] = 1'b1;
    c_sel[0] = 3'd0;
    apply();
    @(posedge clk);
    #2;
    for (int d = 0; d < 3; d++) chk("rst_dominates", d, reg_of(d), 6'h00);
    @(negedge clk);
    #1;
    rst = 1'b0;
    for (int d = 0; d < 3; d++) held[d] = '0;
    #1;
    for (int d = 0; d < 3; d++) begin
      check_comb("post_rst_comb", d);
      push_exp(d);
    end

    // Out-of-range select on the 5-lane instance; 4-bit lanes on the third.
    c_inp[1] = 32'b10110; c_sel[1] = 3'd6; c_v[1] = 1'b1;
    c_inp[2] = 32'h76543210; c_sel[2] = 3'd5; c_v[2] = 1'b1;
    c_v[0] = 1'b0;
    step();
    c_sel[1] = 3'd4; c_v[1] = 1'b0;
    step();

    // Randomised traffic.
    repeat (300) begin
      for (int d = 0; d < 3; d++) begin
        c_inp[d] = $urandom;
        c_sel[d] = 3'($urandom_range(0, 7));
        c_v[d]   = ($urandom_range(0, 3) != 0);
      end
      step();
    end

    repeat (2) @(negedge clk);
    vectors++;
    if (exp_q0.size() + exp_q1.size() + exp_q2.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected responses never checked",
               exp_q0.size() + exp_q1.size() + exp_q2.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_mux_8x1

// File: doc/mux_8x1.md
Name: mux_8x1

Overview:
- Parameterised N:1 selector, default 8 single-bit lanes, with a 3-bit select.
- Provides a combinational output with zero latency.
- Also provides a registered copy with a valid flag, so it can sit directly in a pipelined datapath.
- Used wherever one bit (or one lane) must be picked from a packed vector by index.

Parameters:
- NUM_INP, 8, number of input lanes (>=2).
- WIDTH, 1, bits per lane.
- NUM_SEL, $clog2(NUM_INP), select width (derived; not overridden independently).

Ports:
- clk  input  1  clock for the registered output stage.
- rst  input  1  reset, asynchronous, active-high; clears the registered stage.
- inp  input  NUM_INP*WIDTH  packed lanes; lane k = inp[k*WIDTH +: WIDTH], lane 0 at the LSBs.
- sel  input  NUM_SEL  lane index.
- in_valid  input  1  qualifies inp/sel for the registered stage.
- out  output  WIDTH  combinational selected lane.
- sel_err  output  1  combinational; high when sel >= NUM_INP.
- out_q  output  WIDTH  registered selected lane.
- out_q_valid  output  1  registered in_valid.
- out_q_err  output  1  registered sel_err.

Behaviour:
- Timing: one clock (clk); reset is asynchronous and active-high (rst).
- Combinational path:
  - out = lane[sel], with zero latency; it follows any change on inp or sel in the same delta/timestep.
  - With NUM_INP=8 and WIDTH=1, out = inp[sel].
- Out-of-range select: only possible when NUM_INP is not a power of two.
  - sel >= NUM_INP drives out = 0 and sel_err = 1.
  - Otherwise sel_err = 0.
- Registered stage:
  - Updates on every posedge clk: out_q <= in_valid ? out : out_q.
  - out_q_valid <= in_valid.
  - out_q_err <= in_valid & sel_err.
  - Latency is 1 cycle.
  - out_q holds its last value while in_valid = 0.
- Reset:
  - While rst = 1, out_q = 0, out_q_valid = 0 and out_q_err = 0, immediately and independent of clk.
  - Reset dominates a simultaneous clock edge.
  - The combinational out and sel_err are unaffected by reset.
- Reset deasserted mid-stream: the first edge after release captures the current inputs normally.
- There is no handshake backpressure; the block always accepts input.
- There is no state machine.

Decomposition:
- Shared package mux_pkg:
  - default NUM_INP constant (8);
  - a function returning the lane count from the select width, for checkers.
- One natural sub-module: mux_out_reg, the WIDTH+2 bit async-reset capture register. The selection logic is kept in the top.

Test Plan:
- inp=8'b10110011, sel stepped 0..7 with 5ns holds: out = 1,1,0,0,1,1,0,1 in the same timestep; sel_err = 0 throughout.
- Same inp, in_valid=1, sel=3 then sel=7 on consecutive edges: out_q = 0 then 1, one cycle after each; out_q_valid = 1.
- in_valid dropped after capturing sel=7: out_q stays 1 and out_q_valid = 0 on the next edge.
- rst asserted between edges while out_q=1: out_q and out_q_valid go 0 immediately. On release, with sel=0 and in_valid=1, the next edge gives out_q = 1.
- NUM_INP=5, inp=5'b10110, sel=6: out = 0 and sel_err = 1. With in_valid=1, out_q_err = 1 after one edge.
- WIDTH=4, NUM_INP=8, inp lane k = k, sel=5: out = 4'h5; out_q = 4'h5 after one edge.
